// File: rtl/note_sample_counter.sv
// Phase accumulator and sample counter for one note: walks the sample memory
// region at note_step per increment and flags count_done after note_len samples.
module note_sample_counter #(
   parameter int unsigned ADDR_W = 20,
   parameter int unsigned FRAC_W = 8,
   parameter int unsigned STEP_W = 16,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              new_note,
   input  logic [ADDR_W-1:0] note_start_addr,
   input  logic [CNT_W-1:0]  note_len,
   input  logic [STEP_W-1:0] note_step,
   input  logic              increment,
   input  logic              count_inc,
   input  logic              done_in,
   output logic              count_done,
   output logic              busy,
   output logic [ADDR_W-1:0] sample_addr,
   output logic [FRAC_W-1:0] sample_frac,
   output logic              addr_valid
);

   localparam int unsigned PH_W = ADDR_W + FRAC_W;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACTIVE   = 2'd1,
      FINISHED = 2'd2
   } state_t;

   state_t             state;
   logic [PH_W-1:0]    phase;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   len_r;
   logic [STEP_W-1:0]  step_r;
   logic               first_pend;
   logic [CNT_W-1:0]   count_nxt;
   logic [PH_W-1:0]    step_ext;

   always_comb begin
      count_nxt = count + 1'b1;
      step_ext  = '0;
      step_ext[STEP_W-1:0] = step_r;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         phase      <= '0;
         count      <= '0;
         len_r      <= '0;
         step_r     <= '0;
         first_pend <= 1'b0;
         count_done <= 1'b0;
         addr_valid <= 1'b0;
      end else begin
         addr_valid <= done_in && (state != IDLE);
         if (new_note) begin
            // Starting a note overrides any strobes arriving in the same cycle.
            state      <= ACTIVE;
            phase      <= {note_start_addr, {FRAC_W{1'b0}}};
            count      <= '0;
            len_r      <= (note_len == '0) ? CNT_W'(1) : note_len;
            step_r     <= note_step;
            first_pend <= 1'b1;
            count_done <= 1'b0;
         end else if (state == ACTIVE) begin
            if (increment) begin
               if (first_pend)
                  first_pend <= 1'b0;
               else
                  phase <= phase + step_ext;
            end
            if (count_inc) begin
               count <= count_nxt;
               if (count_nxt == len_r) begin
                  count_done <= 1'b1;
                  state      <= FINISHED;
               end
            end
         end
      end
   end

   assign busy        = (state == ACTIVE);
   assign sample_addr = phase[PH_W-1:FRAC_W];
   assign sample_frac = phase[FRAC_W-1:0];

endmodule

// File: doc/note_sample_counter.md
Name: note_sample_counter

Overview:
Datapath stage directly downstream of the synth sampler's increment-control FSM. It consumes that FSM's increment, count_inc and Done strobes, and advances a fixed-point phase accumulator through a note's sample memory region. It also counts output samples against the note length and returns count_done to the control FSM. On each Done it presents the memory address and interpolation fraction of the next sample to fetch.

Parameters:
ADDR_W, 20, sample memory word address width
FRAC_W, 8, fractional bits of phase and step
STEP_W, 16, width of note_step (unsigned, FRAC_W fractional bits; 0x0100 = native pitch)
CNT_W, 16, width of sample counter and note_len

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
new_note  in  1  one-cycle pulse: latch note_start_addr/note_len/note_step, start note
note_start_addr  in  ADDR_W  first sample word address of note
note_len  in  CNT_W  number of output samples in note
note_step  in  STEP_W  per-sample phase increment
increment  in  1  one-cycle strobe from control FSM: advance phase
count_inc  in  1  one-cycle strobe from control FSM: advance sample count
done_in  in  1  one-cycle Done strobe from control FSM
count_done  out  1  note finished (registered)
busy  out  1  note in progress (state ACTIVE)
sample_addr  out  ADDR_W  integer part of phase
sample_frac  out  FRAC_W  fractional part of phase
addr_valid  out  1  one-cycle pulse: sample_addr/sample_frac valid for fetch

Behaviour:
- Reset (Clk edge with Reset=1, any state, mid-note included): state IDLE, phase=0, count=0, first_pend=0, count_done=0, busy=0, addr_valid=0. All outputs read 0 in the cycle after Reset.
- Phase register is ADDR_W+FRAC_W bits. sample_addr and sample_frac are direct slices of it, with no extra latency.
- FSM states IDLE, ACTIVE, FINISHED. increment and count_inc are ignored in IDLE and FINISHED.
- new_note accepted in any state, highest priority. increment and count_inc in the same cycle are dropped.
- On new_note, the next cycle has: phase={note_start_addr, 0}, count=0, len_r=(note_len==0 ? 1 : note_len), step_r=note_step, first_pend=1, count_done=0, state ACTIVE.
- increment in ACTIVE:
  - if first_pend=1: clear first_pend, leave phase unchanged (first emitted sample = start address);
  - else phase <= phase + zero-extended step_r, modulo 2^(ADDR_W+FRAC_W). Wrap is silent.
- count_inc in ACTIVE: count <= count+1. If count+1 == len_r, the next cycle has count_done=1 and state FINISHED.
- increment and count_inc in the same cycle are both applied.
- addr_valid <= done_in && state!=IDLE. It is one cycle after done_in and reflects the phase at that point. The final sample of a note is still emitted, because Done follows the last count_inc while in FINISHED.
- count_done holds 1 in FINISHED until the next new_note or Reset. busy=0 in IDLE and FINISHED.
- The control FSM samples count_done in its check state, two cycles after count_inc. Registered count_done meets this.

Test Plan:
- Reset asserted for 2 cycles, then released -> count_done=0, busy=0, addr_valid=0, sample_addr=0, sample_frac=0.
- new_note start=0x00100, step=0x0100, len=3, then three rounds of increment / count_inc / done_in -> addr_valid pulses with addr 0x00100, 0x00101, 0x00102, frac 0x00. count_done=1 and busy=0 one cycle after the 3rd count_inc. A 4th increment leaves addr at 0x00102.
- new_note start=0x00010, step=0x0180, len=4 -> emitted (addr,frac) = (0x10,0x00), (0x11,0x80), (0x13,0x00), (0x14,0x80). count_done rises after the 4th count_inc.
- new_note start=0xFFFFF, step=0x0100, len=2 -> emitted addrs 0xFFFFF then 0x00000. count_done after the 2nd count_inc.
- Mid-note (count=1 of len 5): new_note start=0x00200, len=2, same cycle as count_inc -> count=0, count_done=0, next emitted addr 0x00200. count_done after 2 further count_inc.
- new_note with len=0 -> one sample emitted, count_done=1 after the 1st count_inc. Reset pulsed while ACTIVE -> all outputs 0, state IDLE, and done_in gives no addr_valid.
